// File: rtl/div_ctrl_if.sv
// Divider-side bus of div_ctrl: start/annul/operands towards the iterative
// divider and the 64-bit {remainder, quotient} result with its ready flag back.
interface div_ctrl_if;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    modport master (
        output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        input  div_result_i, div_ready_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
        output div_result_i, div_ready_i
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU from EX through the iterative 32-bit divider and
// presents {HI, LO} to the write path. Optional trivial-case bypass: DIV_BYPASS_EN.
module div_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64,
    parameter int unsigned DRAIN_CYCLES   = 32'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    div_ctrl_if.master  dif,
    output logic        stall_req_o,
    output logic        res_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam int unsigned DR_W = $clog2(DRAIN_CYCLES + 32'd1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              signed_r;
    logic [31:0]       op1_r;
    logic [31:0]       op2_r;
    logic [WD_W-1:0]   wd_r;
    logic [DR_W-1:0]   drain_r;
    logic [31:0]       hi_r;
    logic [31:0]       lo_r;
    logic              timeout_r;

    logic              req_s;
    logic              wd_hit_s;
    logic              latch_s;
    logic              capture_s;
    logic [31:0]       cap_hi_s;
    logic [31:0]       cap_lo_s;
    logic              start_s;
    logic              annul_s;
    logic              stall_s;
    logic              timeout_set_s;
    logic              byp_hit_s;
    logic [31:0]       byp_hi_s;
    logic [31:0]       byp_lo_s;

    assign req_s    = ex_div_i & ~flush_i;
    assign wd_hit_s = (wd_r == WD_LAST);

`ifdef DIV_BYPASS_EN
    // Trivial divides resolved on the raw EX operands without the divider
    always_comb begin
        byp_hit_s = 1'b0;
        byp_hi_s  = 32'd0;
        byp_lo_s  = 32'd0;
        if (ex_op2_i == 32'd1) begin
            byp_hit_s = 1'b1;
            byp_lo_s  = ex_op1_i;
        end else if (!ex_signed_i && (ex_op1_i < ex_op2_i)) begin
            byp_hit_s = 1'b1;
            byp_hi_s  = ex_op1_i;
        end else begin
            byp_hit_s = 1'b0;
        end
    end
`else
    assign byp_hit_s = 1'b0;
    assign byp_hi_s  = 32'd0;
    assign byp_lo_s  = 32'd0;
`endif

    // Next-state and divider/pipeline control decode
    always_comb begin
        state_s       = state_r;
        latch_s       = 1'b0;
        capture_s     = 1'b0;
        cap_hi_s      = dif.div_result_i[63:32];
        cap_lo_s      = dif.div_result_i[31:0];
        start_s       = 1'b0;
        annul_s       = 1'b0;
        stall_s       = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    latch_s = 1'b1;
                    stall_s = 1'b1;
                    if (byp_hit_s) begin
                        capture_s = 1'b1;
                        cap_hi_s  = byp_hi_s;
                        cap_lo_s  = byp_lo_s;
                        state_s   = ST_DONE;
                    end else begin
                        state_s   = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Flush beats a same-cycle ready: the killed result is never written
                if (flush_i) begin
                    annul_s = 1'b1;
                    state_s = ST_DRAIN;
                end else if (dif.div_ready_i) begin
                    start_s   = 1'b1;
                    stall_s   = 1'b1;
                    capture_s = 1'b1;
                    state_s   = ST_DONE;
                end else if (wd_hit_s) begin
                    annul_s       = 1'b1;
                    stall_s       = 1'b1;
                    timeout_set_s = 1'b1;
                    state_s       = ST_DRAIN;
                end else begin
                    start_s = 1'b1;
                    stall_s = 1'b1;
                end
            end
            ST_DONE: begin
                stall_s = req_s;
                state_s = ST_IDLE;
            end
            ST_DRAIN: begin
                stall_s = req_s;
                if (drain_r == DR_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches: the divider sees these, never the live EX operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signed_r <= 1'b0;
            op1_r    <= 32'd0;
            op2_r    <= 32'd0;
        end else if (latch_s) begin
            signed_r <= ex_signed_i;
            op1_r    <= ex_op1_i;
            op2_r    <= ex_op2_i;
        end
    end

    // Watchdog runs only in RUN; drain counter only in DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_r    <= {WD_W{1'b0}};
            drain_r <= {DR_W{1'b0}};
        end else begin
            wd_r    <= (state_r == ST_RUN)   ? (wd_r + WD_W'(1))    : {WD_W{1'b0}};
            drain_r <= (state_r == ST_DRAIN) ? (drain_r + DR_W'(1)) : {DR_W{1'b0}};
        end
    end

    // Result capture and sticky watchdog flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            timeout_r <= 1'b0;
        end else begin
            if (capture_s) begin
                hi_r <= cap_hi_s;
                lo_r <= cap_lo_s;
            end
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign dif.div_start_o  = start_s;
    assign dif.div_annul_o  = annul_s;
    assign dif.div_signed_o = signed_r;
    assign dif.div_op1_o    = op1_r;
    assign dif.div_op2_o    = op2_r;

    // The IDLE stall is combinational on EX, so hold it low while reset is asserted
    assign stall_req_o = stall_s & rst;
    assign res_valid_o = (state_r == ST_DONE);
    assign busy_o      = (state_r != ST_IDLE);
    assign hi_o        = hi_r;
    assign lo_o        = lo_r;
    assign timeout_o   = timeout_r;
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-bit multi-cycle divider.
- Latches DIV/DIVU operands and drives the divider's start/annul/signed/operand inputs.
- Holds a pipeline stall request until the 64-bit result is captured, then returns the divider to its free state.
- Handles pipeline flush, divider hang (watchdog), back-to-back divides and result presentation to the HI/LO write path.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in RUN before watchdog abort (must exceed divider latency of 34).
- DRAIN_CYCLES, 3, cycles start_o is held low after an abort so the divider reaches its free state.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_div_i  in  1  EX holds a DIV/DIVU; held high while stalled
- ex_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_op1_i  in  32  dividend
- ex_op2_i  in  32  divisor
- flush_i  in  1  pipeline flush, kills the in-flight divide
- div_start_o  out  1  divider start
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  divider signed select
- div_op1_o  out  32  divider dividend
- div_op2_o  out  32  divider divisor
- div_result_i  in  64  divider result {remainder, quotient}
- div_ready_i  in  1  divider result ready
- stall_req_o  out  1  stall request to pipeline control
- res_valid_o  out  1  one-cycle pulse; hi_o/lo_o valid
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset (rst low, asynchronous): state = IDLE.
  - All outputs 0.
  - Operand registers, watchdog counter and drain counter = 0.
- States: IDLE, RUN, DONE, DRAIN (registered; outputs decoded from state and registers).
- IDLE:
  - If ex_div_i=1 and flush_i=0: latch signed/op1/op2 into div_*_o, go to RUN.
  - stall_req_o is combinationally 1 in that same cycle (ex_div_i & ~flush_i).
- RUN:
  - div_start_o=1 and stall_req_o=1.
  - Operands are driven from the latches, never from ex_*_i; they are stable for the whole operation.
  - The watchdog increments each cycle.
  - flush_i=1 has priority: div_annul_o=1 for this one cycle, start_o=0, stall_req_o=0, go to DRAIN.
  - Otherwise, if div_ready_i=1: capture hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], pulse res_valid_o on the next cycle, go to DONE.
  - At this edge stall_req_o falls, so EX advances exactly once.
  - Otherwise, if the watchdog reaches TIMEOUT_CYCLES-1: set timeout_o, annul for one cycle, go to DRAIN.
- DONE:
  - One cycle; div_start_o=0 so the divider leaves its end state; res_valid_o=1.
  - If ex_div_i=1 (back-to-back divide): stall_req_o=1 and go to IDLE, which then accepts it.
  - Minimum issue interval is therefore 2 idle-side cycles.
- DRAIN:
  - start_o=0 for DRAIN_CYCLES cycles.
  - stall_req_o = ex_div_i & ~flush_i.
  - Then go to IDLE.
  - This covers the divider's divide-by-zero to end-state path, which ignores annul.
- hi_o/lo_o hold the last captured result until the next capture.
- flush_i in IDLE or DONE: the request is ignored and no start is issued.
- flush_i in DRAIN: no effect.
- Divide by zero: no special casing; the divider returns {0,0}, which is passed through.
- A reset mid-operation abandons everything. The divider is reset by the same system reset.

Optional Feature:
- DIV_BYPASS_EN
  - When defined, IDLE checks for trivial cases on the raw operands:
    - op2==1: quotient=op1, remainder=0 (signed or unsigned).
    - DIVU with op1<op2: quotient=0, remainder=op1.
  - On a bypass hit:
    - The result is captured directly.
    - div_start_o is never asserted.
    - The next state is DONE, so res_valid_o pulses the cycle after the request.
    - stall_req_o is 1 for exactly one cycle.
  - When undefined, all divides use the divider and there is no comparator logic.

Test Plan:
- DIVU 100/7, with the divider model using 34-cycle latency:
  - start_o held for 34 cycles.
  - Then res_valid_o pulses with lo_o=14 and hi_o=2.
  - stall_req_o falls together with capture.
  - start_o=0 in DONE.
- DIV 0xFFFFFFF9/2:
  - lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
  - div_signed_o=1 throughout RUN.
- flush_i asserted at RUN cycle 10:
  - div_annul_o=1 for exactly 1 cycle.
  - Then 3 DRAIN cycles with start_o=0.
  - No res_valid_o.
  - stall_req_o low from the flush cycle.
- Divider model never asserts ready:
  - At RUN cycle 64, timeout_o=1 (sticky) and annul pulses.
  - Returns to IDLE after DRAIN.
  - A following DIVU 9/3 completes normally with lo_o=3 and hi_o=0.
- Back-to-back DIVU 10/3 then DIVU 20/6:
  - Two res_valid_o pulses, giving (3,1) then (3,2).
  - The second start_o rises 2 cycles after the first DONE.
- DIV_BYPASS_EN defined, DIVU 5/9 and DIV 0x80000000/1:
  - No start_o.
  - res_valid_o 1 cycle after the request, giving (lo=0, hi=5) and (lo=0x80000000, hi=0).
- rst low mid-RUN:
  - All outputs 0 immediately.
  - State returns to IDLE.
